// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR MAC scheduler: FSM encoding, width helper
// and the round-robin pick used by the arbiter.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_REQ   = 8;
  localparam int REQ_IDX_W = 3;
  localparam int LAT_W     = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit at or above ptr, wrapping at n; lowest offset wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [REQ_IDX_W-1:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] win;
    int idx;
    win = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx]) begin
          win      = '0;
          win[idx] = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fir_mac_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from rr_ptr, pointer moves to
// just past the finishing owner so it is searched last next time.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = idx_w(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [PTR_W-1:0]   owner_idx,
  output logic [NUM_REQ-1:0] winner
);

  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [MAX_REQ-1:0] req_wide;
  logic [MAX_REQ-1:0] win_wide;

  always_comb begin
    req_wide               = '0;
    req_wide[NUM_REQ-1:0]  = req;
    win_wide               = rr_pick(req_wide, REQ_IDX_W'(rr_ptr_reg), NUM_REQ);
    winner                 = '0;
    // Lanes above NUM_REQ are always zero; folding them keeps every bit consumed.
    for (int i = 0; i < MAX_REQ; i++) begin
      winner[i % NUM_REQ] = winner[i % NUM_REQ] | win_wide[i];
    end
  end

  always_comb begin
    rr_ptr_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= '0;
    end else if (advance) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Shares one complex FIR MAC between NUM_REQ channels: grants round-robin, walks
// the tap loop, waits out the MAC pipeline and pulses done to the owner.
module fir_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TAPS     = 20,
  parameter int PIPE_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [$clog2(TAPS)-1:0] tap_idx,
  output logic                    tap_valid,
  output logic                    tap_first,
  output logic                    tap_last,
  output logic                    acc_clear,
  input  logic                    mac_ready,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy
);

  localparam int TAP_W = idx_w(TAPS);
  localparam int PTR_W = idx_w(NUM_REQ);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = (PIPE_LAT > 0) ? LAT_W'(PIPE_LAT - 1) : '0;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [TAP_W-1:0]   tap_idx_reg, tap_idx_next;
  logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
  logic [PTR_W-1:0]   owner_idx;
  logic [NUM_REQ-1:0] winner;
  logic               rr_advance;
  logic               owner_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .advance   (rr_advance),
    .owner_idx (owner_idx),
    .winner    (winner)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_req = |(req & gnt_reg);

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    tap_idx_next = tap_idx_reg;
    lat_cnt_next = lat_cnt_reg;
    rr_advance   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next     = winner;
          tap_idx_next = '0;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (!owner_req) begin
          gnt_next     = '0;
          tap_idx_next = '0;
          rr_advance   = 1'b1;
          state_next   = IDLE;
        end else if (mac_ready) begin
          if (tap_idx_reg == LAST_TAP) begin
            tap_idx_next = '0;
            lat_cnt_next = LAT_INIT;
            state_next   = (PIPE_LAT == 0) ? DONE : DRAIN;
          end else begin
            tap_idx_next = tap_idx_reg + TAP_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!owner_req) begin
          gnt_next     = '0;
          lat_cnt_next = '0;
          rr_advance   = 1'b1;
          state_next   = IDLE;
        end else if (lat_cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - LAT_W'(1);
        end
      end
      DONE: begin
        // Owner dropping req here is ignored: the result is already valid.
        gnt_next   = '0;
        rr_advance = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      tap_idx_reg <= '0;
      lat_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      tap_idx_reg <= tap_idx_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign tap_idx   = tap_idx_reg;
  assign tap_valid = (state_reg == ISSUE);
  assign tap_first = tap_valid && (tap_idx_reg == '0);
  assign tap_last  = tap_valid && (tap_idx_reg == LAST_TAP);
  assign acc_clear = tap_valid && tap_first;
  assign done      = (state_reg == DONE) ? gnt_reg : '0;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: expected done pulses are queued when a
// request is driven and checked (owner and cycle) when the DUT pulses done.
module tb_fir_mac_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req, gnt, done;
  logic [4:0] tap_idx;
  logic       tap_valid, tap_first, tap_last, acc_clear, mac_ready, busy;

  logic [3:0] req0, gnt0, done0;
  logic [4:0] tap_idx0;
  logic       tap_valid0, tap_first0, tap_last0, acc_clear0, mac_ready0, busy0;

  fir_mac_sched #(.NUM_REQ(4), .TAPS(20), .PIPE_LAT(2)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt), .tap_idx(tap_idx),
    .tap_valid(tap_valid), .tap_first(tap_first), .tap_last(tap_last),
    .acc_clear(acc_clear), .mac_ready(mac_ready), .done(done), .busy(busy)
  );

  fir_mac_sched #(.NUM_REQ(4), .TAPS(20), .PIPE_LAT(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .gnt(gnt0), .tap_idx(tap_idx0),
    .tap_valid(tap_valid0), .tap_first(tap_first0), .tap_last(tap_last0),
    .acc_clear(acc_clear0), .mac_ready(mac_ready0), .done(done0), .busy(busy0)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_done(input int ch, input int at);
    exp_t e;
    e.vec = oh(ch);
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: structural invariants every cycle, scoreboard pop on every done.
  always @(negedge clock) begin
    chk("invariants", {29'd0, $onehot0(gnt), ((done & ~gnt) == 4'b0), (!tap_valid || busy)}, 32'd7);
    if (done != 4'b0) begin
      $display("txn done=%b cycle=%0d", done, cyc);
      if (sb.size() == 0) begin
        chk("done_unexpected", {28'd0, done}, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("done_owner", {28'd0, done}, {28'd0, got.vec});
        chk("done_cycle", cyc, got.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, acc;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    reset = 1'b0; req = '0; mac_ready = 1'b1; req0 = '0; mac_ready0 = 1'b1;

    // Reset values
    wait_cyc(2);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tap_valid", {31'd0, tap_valid}, 32'd0);
    chk("rst_tap_idx", {27'd0, tap_idx}, 32'd0);
    reset = 1'b1;
    wait_cyc(3);
    chk("idle_gnt", {28'd0, gnt}, 32'd0);

    // Round-robin with all four requesting continuously
    t0 = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_done(order[k], t0 + 23 + 24 * k);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(t0 + 1 + 24 * k);
      chk("rr_gnt", {28'd0, gnt}, {28'd0, oh(order[k])});
    end
    wait_cyc(t0 + 119);
    req = '0;
    wait_cyc(t0 + 120);
    chk("rr_end_gnt", {28'd0, gnt}, 32'd0);

    // Single request: tap sequence, markers, latency, pass length
    t0 = cyc;
    req = 4'b0001;
    push_done(0, t0 + 23);
    for (int k = 0; k < 20; k++) begin
      wait_cyc(t0 + 1 + k);
      if (k == 0) chk("single_gnt", {28'd0, gnt}, 32'd1);
      chk("single_tap_idx", {27'd0, tap_idx}, k);
      chk("single_tap_valid", {31'd0, tap_valid}, 32'd1);
      chk("single_acc_clear", {31'd0, acc_clear}, {31'd0, k == 0});
      chk("single_tap_last", {31'd0, tap_last}, {31'd0, k == 19});
    end
    wait_cyc(t0 + 21);
    chk("drain_tap_valid", {31'd0, tap_valid}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 23);
    req = '0;
    wait_cyc(t0 + 24);
    chk("single_end_gnt", {28'd0, gnt}, 32'd0);
    chk("single_end_busy", {31'd0, busy}, 32'd0);

    // Backpressure: 5-cycle stall at tap 7 (rr_ptr now 1, channel 1 wins)
    t0 = cyc;
    req = 4'b0010;
    push_done(1, t0 + 28);
    acc = 0;
    for (int c = t0 + 1; c <= t0 + 27; c++) begin
      wait_cyc(c);
      if (c >= t0 + 9 && c <= t0 + 13) begin
        chk("stall_tap_idx", {27'd0, tap_idx}, 32'd7);
        chk("stall_tap_valid", {31'd0, tap_valid}, 32'd1);
      end
      mac_ready = (c >= t0 + 8 && c <= t0 + 12) ? 1'b0 : 1'b1;
      if (tap_valid && mac_ready) acc++;
    end
    chk("stall_taps_accepted", acc, 32'd20);
    wait_cyc(t0 + 28);
    req = '0;
    wait_cyc(t0 + 29);
    chk("stall_end_gnt", {28'd0, gnt}, 32'd0);

    // Reset mid-DRAIN (rr_ptr now 2, channel 2 wins), then restart
    t0 = cyc;
    req = 4'b0100;
    wait_cyc(t0 + 1);
    chk("rstpass_gnt", {28'd0, gnt}, 32'd4);
    wait_cyc(t0 + 21);
    chk("rstpass_draining", {30'd0, busy, tap_valid}, 32'd2);
    reset = 1'b0;
    #1;
    chk("async_gnt", {28'd0, gnt}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {28'd0, done}, 32'd0);
    req = 4'b0010;
    wait_cyc(t0 + 23);
    reset = 1'b1;
    push_done(1, t0 + 46);
    wait_cyc(t0 + 24);
    chk("post_rst_gnt", {28'd0, gnt}, 32'd2);
    wait_cyc(t0 + 46);
    req = '0;
    wait_cyc(t0 + 47);
    chk("post_rst_end_gnt", {28'd0, gnt}, 32'd0);

    // Abort: channel 2 drops at tap 10, pending channel 3 takes over
    t0 = cyc;
    req = 4'b1100;
    wait_cyc(t0 + 1);
    chk("abort_gnt", {28'd0, gnt}, 32'd4);
    wait_cyc(t0 + 11);
    chk("abort_tap_idx", {27'd0, tap_idx}, 32'd10);
    req = 4'b1000;
    push_done(3, t0 + 35);
    wait_cyc(t0 + 12);
    chk("abort_gnt_drop", {28'd0, gnt}, 32'd0);
    wait_cyc(t0 + 13);
    chk("abort_next_gnt", {28'd0, gnt}, 32'd8);
    wait_cyc(t0 + 35);
    req = '0;
    wait_cyc(t0 + 36);
    chk("abort_end_gnt", {28'd0, gnt}, 32'd0);

    // PIPE_LAT=0 instance: done directly after the last tap
    t0 = cyc;
    req0 = 4'b0001;
    wait_cyc(t0 + 1);
    chk("lat0_gnt", {28'd0, gnt0}, 32'd1);
    wait_cyc(t0 + 20);
    chk("lat0_tap_last", {31'd0, tap_last0}, 32'd1);
    chk("lat0_done_early", {28'd0, done0}, 32'd0);
    wait_cyc(t0 + 21);
    chk("lat0_done", {28'd0, done0}, 32'd1);
    chk("lat0_tap_valid", {31'd0, tap_valid0}, 32'd0);
    req0 = '0;
    wait_cyc(t0 + 22);
    chk("lat0_end_gnt", {28'd0, gnt0}, 32'd0);
    chk("lat0_end_done", {28'd0, done0}, 32'd0);

    wait_cyc(cyc + 3);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Round-robin scheduler that shares one complex multiply-accumulate datapath (a TAPS-tap complex FIR MAC) between NUM_REQ filter channels, e.g. the I/Q channel filters of the FM demod chain.
- Grants the MAC to one channel at a time and sequences that channel's tap loop: tap index, first/last markers, accumulator clear.
- Waits out the MAC pipeline latency, then signals completion to the owning channel.
- Sits between the channel FIFO front-ends and the shared MAC. Control only; no sample or coefficient data passes through it.

Parameters:
- NUM_REQ, 4, number of requesting channels (2..8).
- TAPS, 20, taps per filter pass (2..256).
- PIPE_LAT, 2, MAC pipeline depth in cycles from the last tap accepted to the result being valid (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-channel request; held high until done or abort
- gnt  out  NUM_REQ  one-hot grant, registered
- tap_idx  out  $clog2(TAPS)  current tap index to the MAC and the coefficient ROM
- tap_valid  out  1  tap_idx is valid this cycle
- tap_first  out  1  tap_idx == 0 while tap_valid
- tap_last  out  1  tap_idx == TAPS-1 while tap_valid
- acc_clear  out  1  equals tap_valid && tap_first; MAC zeroes its accumulator before adding
- mac_ready  in  1  MAC accepts a tap when tap_valid && mac_ready
- done  out  NUM_REQ  one-cycle pulse to the owner; the MAC result is valid this cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, gnt=0, tap_idx=0, done=0, rr_ptr=0, lat_cnt=0. All outputs are 0 during reset.
- States: IDLE, ISSUE, DRAIN, DONE. Encoding is in the package.
- IDLE:
  - If req != 0, pick the first set bit searching upward from rr_ptr with wrap.
  - Next cycle: gnt = one-hot(winner), tap_idx=0, state=ISSUE.
  - If req == 0, stay in IDLE.
  - Latency from req to the first tap_valid is exactly 1 cycle.
- ISSUE:
  - tap_valid=1.
  - On tap_valid && mac_ready:
    - if tap_idx < TAPS-1: tap_idx increments.
    - if tap_idx == TAPS-1: tap_idx returns to 0, and state goes to DRAIN (lat_cnt=PIPE_LAT-1), or to DONE if PIPE_LAT==0.
  - mac_ready low: hold tap_idx and tap_valid, with no limit on stall length.
- DRAIN: tap_valid=0. lat_cnt decrements each cycle; at 0, go to DONE.
- DONE: done[owner]=1 for exactly one cycle, gnt still held. Next cycle: gnt=0, rr_ptr=(owner+1) mod NUM_REQ, state=IDLE.
- Back-to-back requests: a new grant is possible in the cycle after IDLE is entered. The minimum period per pass is TAPS+PIPE_LAT+2 cycles with mac_ready=1.
- Abort: if req[owner] drops during ISSUE or DRAIN:
  - next state is IDLE, gnt=0, done not pulsed, rr_ptr=owner+1.
  - The MAC result is discarded by the owner.
  - req[owner] low during DONE is ignored; done still pulses.
- Fairness: the owner is never re-granted while another requester is waiting. A single requester may be re-granted immediately.
- A request from a non-owner during ISSUE, DRAIN or DONE has no effect until IDLE.
- Invariants: gnt is one-hot or zero; done ⊆ gnt; tap_valid is never high outside ISSUE.
- Async reset asserted mid-pass: the pass is lost immediately with no done pulse. After release, arbitration restarts from rr_ptr=0.

Decomposition:
- Package fir_sched_pkg holds:
  - state_t enum {IDLE, ISSUE, DRAIN, DONE}
  - function rr_pick(req, ptr), returning a one-hot winner
  - localparams for the TAPS/NUM_REQ index widths
- One sub-module, rr_arbiter: combinational round-robin pick plus the registered rr_ptr update, parameterised by NUM_REQ. The FSM, tap counter and latency counter stay in fir_mac_sched.

Test Plan:
- Single request: req=4'b0001, mac_ready=1, TAPS=20, PIPE_LAT=2.
  - gnt=0001 one cycle later.
  - tap_idx 0..19 on consecutive cycles; acc_clear with idx 0; tap_last with idx 19.
  - done[0] exactly 3 cycles after idx 19.
  - Whole pass is 24 cycles from req to gnt=0.
- Round-robin: req=4'b1111 held continuously. Grant order is 0,1,2,3,0. done pulses once per grant. No two gnt bits are ever high together.
- Backpressure: mac_ready=0 for 5 cycles while tap_idx=7. tap_idx stays 7 with tap_valid=1. The pass completes with exactly 20 accepted taps and done is delayed by 5 cycles.
- Abort: req[2] dropped while tap_idx=10.
  - Next cycle gnt=0 and no done[2].
  - With req[3]=1 pending, gnt=1000 follows 1 cycle later.
- PIPE_LAT=0: done pulses in the cycle after the idx-19 tap is accepted. The DRAIN state is never entered.
- Reset mid-DRAIN: reset low for 2 cycles. All outputs go to 0 asynchronously. After release with req=0010, gnt=0010 next cycle and rr_ptr starts from 0.
